// File: rtl/clk_reset_sequencer.sv
// Power-up / recovery sequencer: pulses PLL RESETB, qualifies LOCK over a
// stability window, then holds the core in reset for a fixed delay. Any lock
// loss or lock timeout re-runs the sequence and bumps a saturating fault count.
module clk_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES  = 16,
  parameter int unsigned LOCK_CYCLES     = 4,
  parameter int unsigned CORE_RST_CYCLES = 128,
  parameter int unsigned LOCK_TIMEOUT    = 4096
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       core_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [3:0] fault_count
);

  localparam int unsigned MaxA   = (LOCK_TIMEOUT > CORE_RST_CYCLES) ? LOCK_TIMEOUT
                                                                    : CORE_RST_CYCLES;
  localparam int unsigned CntMax = (MaxA > PLL_RST_CYCLES) ? MaxA : PLL_RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned LrunW  = $clog2(LOCK_CYCLES + 1);

  // Last in-state cycle values: the transition fires on the edge that ends that cycle.
  localparam logic [CntW-1:0]  PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0]  TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]  CoreLast    = CntW'(CORE_RST_CYCLES - 1);
  localparam logic [CntW-1:0]  CntOne      = CntW'(1);
  localparam logic [LrunW-1:0] LockLast    = LrunW'(LOCK_CYCLES - 1);
  localparam logic [LrunW-1:0] LrunOne     = LrunW'(1);

  typedef enum logic [1:0] {
    StPllRst   = 2'b00,
    StWaitLock = 2'b01,
    StHold     = 2'b10,
    StRun      = 2'b11
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [LrunW-1:0] lrun_q;
  logic [3:0]       fault_q;
  logic [3:0]       fault_sat;
  logic             sync1_q;
  logic             lk_q;
  logic             pll_resetb_q;
  logic             core_reset_q;
  logic             ready_q;

  assign fault_sat = (fault_q == 4'hF) ? 4'hF : fault_q + 4'd1;

  // Two-flop synchronizer for the asynchronous PLL LOCK pin.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_q    <= sync1_q;
    end
  end

  // Sequencer FSM with registered outputs; cnt is cleared on every state entry.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q      <= StPllRst;
      cnt_q        <= '0;
      lrun_q       <= '0;
      fault_q      <= 4'h0;
      pll_resetb_q <= 1'b0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == PllRstLast) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            lrun_q       <= '0;
            pll_resetb_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StWaitLock: begin
          // Lock qualification wins over a timeout landing on the same cycle.
          if (lk_q && (lrun_q == LockLast)) begin
            state_q <= StHold;
            cnt_q   <= '0;
            lrun_q  <= '0;
          end else if (cnt_q == TimeoutLast) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            lrun_q       <= '0;
            fault_q      <= fault_sat;
            pll_resetb_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CntOne;
            lrun_q <= lk_q ? lrun_q + LrunOne : '0;
          end
        end
        StHold: begin
          // Lock loss beats hold completion on the same cycle.
          if (!lk_q) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            fault_q      <= fault_sat;
            pll_resetb_q <= 1'b0;
          end else if (cnt_q == CoreLast) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            core_reset_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRun: begin
          if (!lk_q) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            fault_q      <= fault_sat;
            pll_resetb_q <= 1'b0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= StPllRst;
          cnt_q        <= '0;
          lrun_q       <= '0;
          pll_resetb_q <= 1'b0;
          core_reset_q <= 1'b1;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign core_reset  = core_reset_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign fault_count = fault_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer: directed scenarios plus randomized lock traffic,
// every cycle compared against a phase/elapsed-time reference model.
module tb_clk_reset_sequencer;

  localparam int unsigned PRC = 16;
  localparam int unsigned LC  = 4;
  localparam int unsigned CRC = 128;
  localparam int unsigned LT  = 256;

  logic       clk_core = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       pll_resetb;
  logic       core_reset;
  logic       ready;
  logic [1:0] state;
  logic [3:0] fault_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;

  // Reference model: phase 0..3, cycles elapsed in phase, consecutive synced highs.
  int m_phase = 0;
  int m_age   = 0;
  int m_run   = 0;
  int m_fault = 0;
  bit pin_hist[$];

  clk_reset_sequencer #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_CYCLES    (LC),
    .CORE_RST_CYCLES(CRC),
    .LOCK_TIMEOUT   (LT)
  ) dut (
    .clk_core   (clk_core),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pll_resetb (pll_resetb),
    .core_reset (core_reset),
    .ready      (ready),
    .state      (state),
    .fault_count(fault_count)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
  endtask

  function automatic int go_fault(input int f);
    return (f >= 15) ? 15 : f + 1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit lk;
    if (reset) begin
      m_phase = 0; m_age = 0; m_run = 0; m_fault = 0;
      pin_hist.delete();
      return;
    end
    lk = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size() - 2] : 1'b0;
    pin_hist.push_back(pll_locked);
    if (pin_hist.size() > 3) void'(pin_hist.pop_front());
    case (m_phase)
      0: begin
        if (m_age + 1 == PRC) begin m_phase = 1; m_age = 0; m_run = 0; end
        else m_age++;
      end
      1: begin
        m_run = lk ? m_run + 1 : 0;
        if (m_run == LC) begin m_phase = 2; m_age = 0; end
        else if (m_age + 1 == LT) begin m_phase = 0; m_age = 0; m_fault = go_fault(m_fault); end
        else m_age++;
      end
      2: begin
        if (!lk) begin m_phase = 0; m_age = 0; m_fault = go_fault(m_fault); end
        else if (m_age + 1 == CRC) begin m_phase = 3; m_age = 0; end
        else m_age++;
      end
      default: begin
        if (!lk) begin m_phase = 0; m_age = 0; m_fault = go_fault(m_fault); end
      end
    endcase
  endtask

  // One clock: update model, wait past the edge, compare every output.
  task automatic step();
    logic [8:0] exp;
    model_edge();
    @(posedge clk_core);
    #1;
    cyc++;
    exp = {m_phase[1:0], 1'(m_phase != 0), 1'(m_phase != 3), 1'(m_phase == 3), m_fault[3:0]};
    check("outputs{state,resetb,core_rst,ready,faults}",
          {23'd0, state, pll_resetb, core_reset, ready, fault_count}, {23'd0, exp});
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int budget,
                            output int n);
    n = 0;
    while (state !== target && n < budget) begin
      step();
      n++;
    end
    check(tag, {30'd0, state}, {30'd0, target});
  endtask

  task automatic wait_ready(input string tag, input int budget, output int n);
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int n;
    bit pat[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset values
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (3) step();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_pll_resetb", {31'd0, pll_resetb}, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_fault", {28'd0, fault_count}, 32'd0);

    // Clean boot: PLL locks 20 cycles after RESETB rises
    reset = 1'b0;
    wait_state("boot_wait_lock", 2'b01, 100, n);
    check("boot_pll_rst_len", n, PRC);
    repeat (20) step();
    pll_locked = 1'b1;
    wait_ready("boot_ready", 1000, n);
    check("boot_latency", n, 2 + LC + CRC);
    check("boot_core_reset", {31'd0, core_reset}, 32'd0);
    check("boot_fault", {28'd0, fault_count}, 32'd0);
    repeat (10) step();

    // Lock loss in RUN: 3-edge latency, then relock and full re-sequence
    pll_locked = 1'b0;
    step();
    step();
    check("loss_core_reset_2edges", {31'd0, core_reset}, 32'd0);
    step();
    check("loss_core_reset_3edges", {31'd0, core_reset}, 32'd1);
    check("loss_ready", {31'd0, ready}, 32'd0);
    check("loss_pll_resetb", {31'd0, pll_resetb}, 32'd0);
    check("loss_state", {30'd0, state}, 32'd0);
    check("loss_fault", {28'd0, fault_count}, 32'd1);
    wait_state("relock_wait_lock", 2'b01, 100, n);
    repeat (5) step();
    pll_locked = 1'b1;
    wait_ready("relock_ready", 1000, n);

    // One-cycle reset while in RUN
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("runrst_state", {30'd0, state}, 32'd0);
    check("runrst_outputs", {29'd0, pll_resetb, core_reset, ready}, 32'b010);
    check("runrst_fault", {28'd0, fault_count}, 32'd0);

    // Glitchy lock: restart of the qualification run
    pll_locked = 1'b0;
    wait_state("glitch_wait_lock", 2'b01, 100, n);
    check("restart_pll_rst_len", n, PRC);
    for (int i = 0; i < 8; i++) begin
      pll_locked = pat[i];
      step();
    end
    pll_locked = 1'b1;
    step();
    check("glitch_not_yet_hold", {30'd0, state}, 32'd1);
    step();
    check("glitch_hold", {30'd0, state}, 32'd2);

    // Lock loss landing on the final HOLD cycle
    for (int j = 1; j <= 127; j++) begin
      pll_locked = (j < 126);
      step();
    end
    check("final_hold_still_hold", {30'd0, state}, 32'd2);
    step();
    check("final_hold_state", {30'd0, state}, 32'd0);
    check("final_hold_ready", {31'd0, ready}, 32'd0);
    check("final_hold_fault", {28'd0, fault_count}, 32'd1);

    // No lock at all: repeated timeouts, fault count saturates
    reset = 1'b1;
    step();
    reset = 1'b0;
    pll_locked = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      wait_state("nolock_enter", 2'b01, 100, n);
      n = 0;
      while (state === 2'b01 && n < LT + 10) begin
        step();
        n++;
      end
      check("nolock_wait_len", n, LT);
      check("nolock_fault", {28'd0, fault_count}, (k < 15) ? k : 15);
    end

    // Randomized lock traffic with occasional resets
    for (int e = 0; e < 40; e++) begin
      int dur;
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      pll_locked = ($urandom_range(0, 3) != 0);
      dur = pll_locked ? $urandom_range(1, 400) : $urandom_range(1, 40);
      repeat (dur) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
